// File: rtl/dragster_spi_pkg.sv
// Shared frame constants and FSM state type for the dragster SPI register responder.
package dragster_spi_pkg;
    localparam int FRAME_BITS    = 16;
    localparam int DATA_MSB      = 15;
    localparam int READ_FLAG_BIT = 7;
    localparam int ADDR_BITS     = 7;
    localparam int CNT_BITS      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;
endpackage

// File: rtl/spi_input_sync.sv
// Synchronizers for sclk/ss_n/mosi plus edge detection of sclk and ss_n in the clk domain.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic mosi_s,
    output logic ss_n_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise
);
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   ss_prev;
    logic                   sclk_now;

    // ss_n chain resets low so a select still held low at reset release does not fake a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_now = sclk_sync[SYNC_STAGES-1];
    assign ss_n_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];

    // Gating on the previous select value keeps an sclk edge that coincides with the ss_n rise.
    assign sclk_rise = sclk_now & ~sclk_prev & ~ss_prev;
    assign sclk_fall = ~sclk_now & sclk_prev & ~ss_prev;
    assign ss_fall   = ~ss_n_s & ss_prev;
    assign ss_rise   = ss_n_s & ~ss_prev;
endmodule

// File: rtl/dragster_spi_responder.sv
// SPI mode-0 register-bank responder: 16-bit frames {data, rd/addr}, optional readback
// on miso when DRAGSTER_SPI_READBACK_EN is defined.
module dragster_spi_responder
    import dragster_spi_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [NUM_REGS*8-1:0] reg_file,
    output logic                  wr_strobe,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_error
);
    // state     | meaning
    // ST_IDLE   | ss_n high, waiting for a select falling edge
    // ST_SHIFT  | ss_n low, shifting frame bits in on sclk rises
    // ST_COMMIT | one cycle after a full frame; write/read-load results are visible

    state_t                  state_q, state_d;
    logic [CNT_BITS-1:0]     bit_cnt_q;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [NUM_REGS*8-1:0]   reg_q;
    logic                    mosi_s, ss_n_s, sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                    shift_en, clear, complete, abort;
    logic [ADDR_BITS-1:0]    frame_addr;
    logic [7:0]              frame_data;
    logic                    frame_rd;
    logic                    addr_hit;
    logic                    wr_hit;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .mosi_s    (mosi_s),
        .ss_n_s    (ss_n_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise)
    );

    assign shift_d    = {shift_q[FRAME_BITS-2:0], mosi_s};
    assign frame_addr = shift_d[ADDR_BITS-1:0];
    assign frame_data = shift_d[DATA_MSB -: 8];
    assign frame_rd   = shift_d[READ_FLAG_BIT];
    assign reg_file   = reg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        clear    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_SHIFT;
                    clear   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == CNT_BITS'(FRAME_BITS - 1)) begin
                        complete = 1'b1;
                        state_d  = ST_COMMIT;
                    end
                end
                if (ss_rise && !complete) begin
                    state_d = ST_IDLE;
                    abort   = (bit_cnt_q != '0);
                end
            end
            ST_COMMIT: state_d = ss_n_s ? ST_IDLE : ST_SHIFT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == ADDR_BITS'(i)) addr_hit = 1'b1;
        end
    end

    assign wr_hit = complete & ~frame_rd & addr_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            reg_q       <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_error <= 1'b0;
        end else begin
            wr_strobe   <= wr_hit;
            frame_error <= abort;
            if (clear) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (shift_en) begin
                shift_q   <= shift_d;
                bit_cnt_q <= complete ? '0 : bit_cnt_q + CNT_BITS'(1);
            end
            if (wr_hit) begin
                wr_addr <= frame_addr;
                wr_data <= frame_data;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (frame_addr == ADDR_BITS'(i)) reg_q[i*8 +: 8] <= frame_data;
                end
            end
        end
    end

`ifdef DRAGSTER_SPI_READBACK_EN
    logic [7:0]            rd_byte;
    logic [FRAME_BITS-1:0] tx_q;

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == ADDR_BITS'(i)) rd_byte = reg_q[i*8 +: 8];
        end
    end

    // Loaded one position low: the trailing sclk fall of the read frame moves the byte MSB to the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q <= '0;
        end else if (complete) begin
            tx_q <= frame_rd ? {1'b0, rd_byte, 7'b0} : '0;
        end else if (sclk_fall && state_q != ST_IDLE) begin
            tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign miso = ss_n_s ? 1'b0 : tx_q[FRAME_BITS-1];
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign miso             = 1'b0;
`endif
endmodule

// File: tb/tb_dragster_spi_responder.sv
// Directed bench for dragster_spi_responder with a write/miso scoreboard.
module tb_dragster_spi_responder;
    localparam int NUM_REGS = 16;
    localparam int HALF     = 8;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic                  sclk  = 1'b0;
    logic                  ss_n  = 1'b1;
    logic                  mosi  = 1'b0;
    logic                  miso;
    logic [NUM_REGS*8-1:0] reg_file;
    logic                  wr_strobe;
    logic [6:0]            wr_addr;
    logic [7:0]            wr_data;
    logic                  frame_error;

    int         tests = 0;
    int         fails = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         e0;
    logic [22:0] obs_q[$];
    logic [22:0] exp_q[$];
    logic [7:0]  model[NUM_REGS];
    logic [7:0]  pending_tx;
    logic [15:0] rx_dummy;

    always #5 clk = ~clk;

    dragster_spi_responder #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .reg_file    (reg_file),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_error (frame_error)
    );

    always @(negedge clk) begin
        if (wr_strobe) obs_q.push_back({wr_addr, wr_data, reg_file[wr_addr*8 +: 8]});
        if (frame_error) err_cnt++;
        if (wr_strobe && frame_error) both_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*8-1:0] model_flat();
        logic [NUM_REGS*8-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            wait_clks(HALF);
            rx = {rx[14:0], miso};
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic sel_low();
        ss_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic sel_high();
        wait_clks(HALF);
        ss_n = 1'b1;
        wait_clks(2*HALF);
    endtask

    task automatic send_frame(input logic [15:0] w, input string tag);
        logic [15:0] rx;
        logic [15:0] exp_miso;
        int          a;
        a = int'(w[6:0]);
`ifdef DRAGSTER_SPI_READBACK_EN
        exp_miso = {pending_tx, 8'h00};
`else
        exp_miso = '0;
`endif
        if (!w[7]) begin
            if (a < NUM_REGS) begin
                exp_q.push_back({w[6:0], w[15:8], w[15:8]});
                model[a] = w[15:8];
            end
            pending_tx = 8'h00;
        end else begin
            pending_tx = (a < NUM_REGS) ? model[a] : 8'h00;
        end
        shift_bits(w, 16, rx);
        chk({tag, ":miso"}, 128'(rx), 128'(exp_miso));
    endtask

    task automatic drain(input string tag);
        chk({tag, ":n_writes"}, 128'(obs_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, ":write"}, 128'(obs_q.pop_front()), 128'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
        chk({tag, ":reg_file"}, 128'(reg_file), 128'(model_flat()));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        pending_tx = 8'h00;

        wait_clks(5);
        chk("rst:reg_file", 128'(reg_file), 128'(model_flat()));
        chk("rst:miso", 128'(miso), 128'(0));
        chk("rst:wr_strobe", 128'(wr_strobe), 128'(0));
        chk("rst:frame_error", 128'(frame_error), 128'(0));
        chk("rst:wr_addr", 128'(wr_addr), 128'(0));
        chk("rst:wr_data", 128'(wr_data), 128'(0));
        reset = 1'b0;
        wait_clks(5);

        sel_low(); send_frame(16'hA901, "single"); sel_high();
        drain("single");

        e0 = err_cnt;
        sel_low();
        send_frame(16'h1305, "b2b0"); send_frame(16'h3202, "b2b1");
        send_frame(16'hC003, "b2b2"); send_frame(16'h1F09, "b2b3");
        send_frame(16'hA901, "b2b4");
        sel_high();
        drain("b2b");
        chk("b2b:no_error", 128'(err_cnt - e0), 128'(0));

        e0 = err_cnt;
        sel_low(); shift_bits(16'h5504, 9, rx_dummy); sel_high();
        drain("abort");
        chk("abort:one_error", 128'(err_cnt - e0), 128'(1));

        sel_low(); send_frame(16'h5A0F, "top_reg"); sel_high();
        drain("top_reg");
        sel_low(); send_frame(16'h7730, "addr48"); sel_high();
        drain("addr48");
        sel_low(); send_frame(16'h4410, "addr16"); sel_high();
        drain("addr16");

        sel_low(); send_frame(16'h0081, "rd1"); sel_high();
        chk("rd1:miso_idle", 128'(miso), 128'(0));
        sel_low(); send_frame(16'h0000, "after_rd1"); sel_high();
        drain("readback");
        sel_low();
        send_frame(16'h0085, "rd5"); send_frame(16'h00C0, "rd64"); send_frame(16'h0000, "after_rd64");
        sel_high();
        drain("readback_b2b");

        e0 = err_cnt;
        sel_low(); shift_bits(16'h6602, 8, rx_dummy);
        reset = 1'b1;
        wait_clks(3);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        pending_tx = 8'h00;
        exp_q.delete();
        obs_q.delete();
        chk("midrst:reg_file", 128'(reg_file), 128'(model_flat()));
        reset = 1'b0;
        wait_clks(2);
        shift_bits(16'h0200, 8, rx_dummy);
        sel_high();
        drain("midrst_tail");
        chk("midrst:no_error", 128'(err_cnt - e0), 128'(0));
        sel_low(); send_frame(16'h6602, "after_rst"); sel_high();
        drain("after_rst");

        chk("strobe_error_exclusive", 128'(both_cnt), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dragster_spi_responder.md
DRAGSTER_SPI_RESPONDER -- requirements
Module: dragster_spi_responder

Interface
REQ-001 Parameter NUM_REGS, default 16: number of 8-bit registers in the bank (1..128).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, ss_n and mosi (minimum 2).
REQ-003 clk  input  1  system clock; all logic runs on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
REQ-006 ss_n  input  1  active-low slave select from the master.
REQ-007 mosi  input  1  serial data from the master, MSB first.
REQ-008 miso  output  1  serial readback data to the master.
REQ-009 reg_file  output  NUM_REGS*8  flat register bank; register i occupies bits [8i+7:8i].
REQ-010 wr_strobe  output  1  one-clk pulse when a register is written.
REQ-011 wr_addr  output  7  address of the last write; valid while wr_strobe is high.
REQ-012 wr_data  output  8  data of the last write; valid while wr_strobe is high.
REQ-013 frame_error  output  1  one-clk pulse when a frame is aborted.

Function
REQ-014 sclk, ss_n and mosi SHALL pass through SYNC_STAGES flip-flops before use; clk SHALL be at least 4x the sclk frequency.
REQ-015 Rising and falling sclk edges SHALL be detected on the synchronized signal only; edges while synchronized ss_n is high SHALL be ignored.
REQ-016 A frame SHALL be 16 bits, MSB first: bits[15:8] data byte, bits[7:0] address byte; address byte bit7 = read flag, bits[6:0] = register address.
REQ-017 A falling edge of synchronized ss_n SHALL clear the 5-bit bit counter and the receive shift register.
REQ-018 mosi SHALL be shifted in on each synchronized sclk rising edge, and the bit counter SHALL be incremented.
REQ-019 On the 16th rising edge the frame SHALL complete and the bit counter SHALL return to 0, so back-to-back frames under one ss_n assertion are accepted.
REQ-020 Write frame (read flag 0, address < NUM_REGS): the register SHALL update and wr_strobe/wr_addr/wr_data SHALL be valid on the clk cycle after the 16th synchronized rising edge.
REQ-021 Write frame to address >= NUM_REGS: no register change, no wr_strobe.
REQ-022 State machine states: IDLE (ss_n high), SHIFT (ss_n low, bits being received), COMMIT (one cycle, write/read-load), then back to SHIFT.
REQ-023 A synchronized ss_n rise in SHIFT with bit count 1..15 SHALL discard the frame, pulse frame_error for one cycle and enter IDLE; a rise at bit count 0 SHALL NOT raise an error.
REQ-024 When a write and an ss_n rise are seen in the same cycle, the completed frame SHALL take priority (commit, no error).
REQ-025 wr_strobe and frame_error SHALL never both be high in the same cycle.

Reset
REQ-026 reset SHALL force IDLE, clear all reg_file bits to 0x00, the counter and the shift registers, and drive miso, wr_strobe, wr_addr, wr_data and frame_error low.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release, the first frame received SHALL begin at the next ss_n falling edge.

Configuration
REQ-028 Macro DRAGSTER_SPI_READBACK_EN defined: a read frame (flag 1) SHALL load reg_file[addr] (0x00 if addr >= NUM_REGS) into the transmit register in COMMIT, with no write.
REQ-029 With DRAGSTER_SPI_READBACK_EN defined, the next frame SHALL carry that byte on miso in bits 15..8, changing on synchronized sclk falling edges, with bits 7..0 as 0.
REQ-030 With DRAGSTER_SPI_READBACK_EN defined, miso SHALL be 0 while ss_n is high.
REQ-031 Macro undefined: read frames SHALL be ignored (no write, no strobe), and miso SHALL be held 0.

Structure
REQ-032 A package dragster_spi_pkg SHALL hold FRAME_BITS=16, DATA_MSB=15, READ_FLAG_BIT=7, ADDR_BITS=7 and the state enumeration.
REQ-033 A sub-module spi_input_sync SHALL contain the synchronizers and the sclk rise/fall and ss_n fall/rise edge detection.

Verification
REQ-034 Frame 0xA901 (ss_n framed) -> reg_file[1]=0xA9, one wr_strobe with wr_addr=1, wr_data=0xA9.
REQ-035 Five frames 0x1305, 0x3202, 0xC003, 0x1F09, 0xA901 under one ss_n -> regs 5,2,3,9,1 = 0x13,0x32,0xC0,0x1F,0xA9, five strobes, no frame_error.
REQ-036 ss_n raised after 9 bits of 0x5504 -> frame_error pulses once, reg_file[4] stays 0x00.
REQ-037 Frame 0x7730 (addr 48 >= 16) -> no strobe, reg_file unchanged.
REQ-038 DRAGSTER_SPI_READBACK_EN defined: write 0xA901, send read 0x0081, then 0x0000 -> miso shifts 0xA9 then 0x00; undefined -> miso stays 0.
REQ-039 reset pulsed at bit 8 of 0x6602 -> reg_file[2]=0x00; the following full frame 0x6602 sets reg_file[2]=0x66.
